wishbone_board_arbiter: RTL and testbench

//  Shares the single-port Wishbone board memory (16x16 cells, 8-bit cell in dat[7:0]) between
//  NUM_MASTERS requesters: game FSM, reveal/flood-fill engine, VGA board renderer.

---
 rtl/wishbone_board_arbiter_if.sv | 35 +++
 rtl/wishbone_board_arbiter.sv | 139 +++++++++++++
 tb/tb_wishbone_board_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wishbone_board_arbiter_if.sv
// Wishbone bus bundle between the board-memory arbiter, its requesters and the board memory.
// The arbiter takes the slave modport; the requester/memory side takes the master modport.
interface wishbone_board_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16
);
  logic [NUM_MASTERS-1:0]        m_cyc;
  logic [NUM_MASTERS-1:0]        m_stb;
  logic [NUM_MASTERS-1:0]        m_we;
  logic [NUM_MASTERS*ADDR_W-1:0] m_adr;
  logic [NUM_MASTERS*DATA_W-1:0] m_dat_w;
  logic [DATA_W-1:0]             m_dat_r;
  logic [NUM_MASTERS-1:0]        m_ack;
  logic [NUM_MASTERS-1:0]        m_stall;
  logic                          s_cyc;
  logic                          s_stb;
  logic                          s_we;
  logic [ADDR_W-1:0]             s_adr;
  logic [DATA_W-1:0]             s_dat_w;
  logic [DATA_W-1:0]             s_dat_r;
  logic                          s_ack;
  logic                          s_stall;
  logic [NUM_MASTERS-1:0]        gnt;

  modport slave (
    input  m_cyc, m_stb, m_we, m_adr, m_dat_w, s_dat_r, s_ack, s_stall,
    output m_dat_r, m_ack, m_stall, s_cyc, s_stb, s_we, s_adr, s_dat_w, gnt
  );

  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_dat_w, s_dat_r, s_ack, s_stall,
    input  m_dat_r, m_ack, m_stall, s_cyc, s_stb, s_we, s_adr, s_dat_w, gnt
  );
endinterface

// File: rtl/wishbone_board_arbiter.sv
// Shares the single-port board memory between NUM_MASTERS Wishbone requesters, one whole
// cycle per owner, with one idle GAP cycle between owners so a late ack cannot be misrouted.
module wishbone_board_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int FIXED_PRIO  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  wishbone_board_arbiter_if.slave       bus
);
  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [NUM_MASTERS-1:0] ONE_V = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [NUM_MASTERS-1:0] gnt_r, gnt_nxt_s;
  logic [PTR_W-1:0]       ptr_r, ptr_nxt_s;
  logic [PTR_W-1:0]       own_s;
  logic [PTR_W-1:0]       win_s;
  logic                   win_vld_s;
  logic [PTR_W-1:0]       idx_s;
  logic [PTR_W:0]         sum_s;

  logic                   s_cyc_s, s_stb_s, s_we_s;
  logic [ADDR_W-1:0]      s_adr_s;
  logic [DATA_W-1:0]      s_dat_w_s;
  logic [NUM_MASTERS-1:0] m_ack_s, m_stall_s;

  // Encode the one-hot grant register into the owner index
  always_comb begin
    own_s = {PTR_W{1'b0}};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      own_s = gnt_r[i] ? PTR_W'(i) : own_s;
    end
  end

  // Pick the winner among m_cyc requests; scan backwards so the highest-precedence hit lands last
  always_comb begin
    win_s     = {PTR_W{1'b0}};
    win_vld_s = 1'b0;
    idx_s     = {PTR_W{1'b0}};
    sum_s     = {(PTR_W+1){1'b0}};
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      sum_s = {1'b0, ptr_r} + (PTR_W+1)'(k);
      if (FIXED_PRIO != 0) begin
        idx_s = PTR_W'(k);
      end else if (sum_s >= (PTR_W+1)'(NUM_MASTERS)) begin
        idx_s = PTR_W'(sum_s - (PTR_W+1)'(NUM_MASTERS));
      end else begin
        idx_s = PTR_W'(sum_s);
      end
      win_vld_s = win_vld_s | bus.m_cyc[idx_s];
      win_s     = bus.m_cyc[idx_s] ? idx_s : win_s;
    end
  end

  // Next state: grant from IDLE/GAP, hold while the owner keeps cyc, release into one GAP cycle
  always_comb begin
    state_nxt_s = state_r;
    gnt_nxt_s   = gnt_r;
    ptr_nxt_s   = ptr_r;
    case (state_r)
      IDLE, GAP: begin
        if (win_vld_s) begin
          state_nxt_s = GRANT;
          gnt_nxt_s   = ONE_V << win_s;
        end else begin
          state_nxt_s = IDLE;
          gnt_nxt_s   = {NUM_MASTERS{1'b0}};
        end
      end
      GRANT: begin
        if (!bus.m_cyc[own_s]) begin
          state_nxt_s = GAP;
          gnt_nxt_s   = {NUM_MASTERS{1'b0}};
          ptr_nxt_s   = (own_s == PTR_W'(NUM_MASTERS - 1)) ? {PTR_W{1'b0}} : own_s + PTR_W'(1);
        end else begin
          state_nxt_s = GRANT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        gnt_nxt_s   = {NUM_MASTERS{1'b0}};
      end
    endcase
  end

  // Bus steering: only the owner sees the memory; everyone else is stalled with no ack
  always_comb begin
    s_cyc_s   = 1'b0;
    s_stb_s   = 1'b0;
    s_we_s    = 1'b0;
    s_adr_s   = {ADDR_W{1'b0}};
    s_dat_w_s = {DATA_W{1'b0}};
    m_ack_s   = {NUM_MASTERS{1'b0}};
    m_stall_s = {NUM_MASTERS{1'b1}};
    if (state_r == GRANT) begin
      s_cyc_s          = bus.m_cyc[own_s];
      s_stb_s          = bus.m_cyc[own_s] & bus.m_stb[own_s];
      s_we_s           = bus.m_we[own_s];
      s_adr_s          = bus.m_adr[int'(own_s)*ADDR_W +: ADDR_W];
      s_dat_w_s        = bus.m_dat_w[int'(own_s)*DATA_W +: DATA_W];
      m_ack_s[own_s]   = bus.s_ack;
      m_stall_s[own_s] = bus.s_stall;
    end else begin
      m_ack_s = {NUM_MASTERS{1'b0}};
    end
  end

  // State, grant and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      gnt_r   <= {NUM_MASTERS{1'b0}};
      ptr_r   <= {PTR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      gnt_r   <= gnt_nxt_s;
      ptr_r   <= ptr_nxt_s;
    end
  end

  assign bus.s_cyc   = s_cyc_s;
  assign bus.s_stb   = s_stb_s;
  assign bus.s_we    = s_we_s;
  assign bus.s_adr   = s_adr_s;
  assign bus.s_dat_w = s_dat_w_s;
  assign bus.m_ack   = m_ack_s;
  assign bus.m_stall = m_stall_s;
  assign bus.m_dat_r = bus.s_dat_r;
  assign bus.gnt     = gnt_r;
endmodule

// File: tb/tb_wishbone_board_arbiter.sv
// Directed bench for wishbone_board_arbiter: a board-memory model, a per-cycle master driver,
// and a monitor holding the ack scoreboard plus grant-order history.
module tb_wishbone_board_arbiter;
  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 16;

  typedef struct packed {
    logic [1:0]    mst;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wishbone_board_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus();

  wishbone_board_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Board memory: registered ack, read data from the latched address; adr 8'h30 acks twice
  logic [DW-1:0] mem [256];
  logic [AW-1:0] adr_q;
  logic          ack_q, ack2_q;
  bit            mem_ready;
  always @(posedge clk) begin
    if (rst) begin
      ack_q  <= 1'b0;
      ack2_q <= 1'b0;
      adr_q  <= 8'h00;
      if (!mem_ready) begin
        for (int i = 0; i < 256; i++) mem[i] <= 16'hA500 | 16'(i);
        mem_ready <= 1'b1;
      end
    end else begin
      ack_q  <= bus.s_cyc & bus.s_stb;
      ack2_q <= ack_q & (adr_q == 8'h30);
      if (bus.s_cyc & bus.s_stb) begin
        adr_q <= bus.s_adr;
        if (bus.s_we) mem[bus.s_adr] <= bus.s_dat_w;
      end
    end
  end
  assign bus.s_ack   = ack_q | ack2_q;
  assign bus.s_stall = 1'b0;
  assign bus.s_dat_r = mem[adr_q];

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;
  op_t cmds[$];
  op_t sbq[$];
  int got_order[$];
  int gaps[$];
  int last_drop[N];
  int gnt_cycle[N];
  int zero_run;
  bit seen_owner;
  logic [N-1:0] prev_gnt;
  logic [N-1:0] stb_on, wait_ack, drop_on_ack;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic op_t mk(input int m, input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    op_t o;
    o.mst = 2'(m);
    o.we  = we;
    o.adr = adr;
    o.dat = dat;
    return o;
  endfunction

  function automatic int find_cmd(input int m);
    for (int j = 0; j < cmds.size(); j++) begin
      if (int'(cmds[j].mst) == m) return j;
    end
    return -1;
  endfunction

  // Pack a history queue into nibbles (value+1) so order and length are both visible
  function automatic logic [31:0] pack(input int q[$]);
    logic [31:0] v;
    v = 32'd0;
    foreach (q[j]) v = (v << 4) | 32'(q[j] + 1);
    return v;
  endfunction

  // One driver step at the falling edge for every master
  task automatic tick();
    int k;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      k = find_cmd(i);
      if (stb_on[i]) begin
        bus.m_stb[i] = 1'b0;
        stb_on[i]    = 1'b0;
        wait_ack[i]  = 1'b1;
      end
      if (wait_ack[i]) begin
        if (bus.m_ack[i]) begin
          wait_ack[i] = 1'b0;
          if (k < 0 || drop_on_ack[i]) begin
            bus.m_cyc[i] = 1'b0;
            last_drop[i] = cyc_cnt;
          end
        end
      end else if (bus.m_cyc[i] && bus.gnt[i] && k >= 0) begin
        bus.m_stb[i]               = 1'b1;
        bus.m_we[i]                = cmds[k].we;
        bus.m_adr[i*AW +: AW]      = cmds[k].adr;
        bus.m_dat_w[i*DW +: DW]    = cmds[k].dat;
        sbq.push_back(cmds[k]);
        cmds.delete(k);
        stb_on[i] = 1'b1;
      end else if (!bus.m_cyc[i] && k >= 0) begin
        bus.m_cyc[i] = 1'b1;
      end
    end
  endtask

  task automatic clear_masters();
    bus.m_cyc   = {N{1'b0}};
    bus.m_stb   = {N{1'b0}};
    bus.m_we    = {N{1'b0}};
    bus.m_adr   = {(N*AW){1'b0}};
    bus.m_dat_w = {(N*DW){1'b0}};
    stb_on      = {N{1'b0}};
    wait_ack    = {N{1'b0}};
    drop_on_ack = {N{1'b0}};
    cmds.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_masters();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_idle(input string name);
    int n;
    n = 0;
    while ((cmds.size() != 0 || stb_on != 0 || wait_ack != 0 || bus.m_cyc != 0 || sbq.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check({name, "_finished"}, 32'(n < 300), 32'd1);
  endtask

  // Monitor: bus invariants, grant history, and the ack scoreboard
  always @(posedge clk) begin
    op_t e;
    #1;
    cyc_cnt++;
    if (rst) begin
      sbq.delete();
      got_order.delete();
      gaps.delete();
      zero_run   = 0;
      seen_owner = 1'b0;
      prev_gnt   = {N{1'b0}};
    end else begin
      check("gnt_onehot", 32'($onehot0(bus.gnt)), 32'd1);
      check("dat_r_bcast", 32'(bus.m_dat_r), 32'(bus.s_dat_r));
      if (bus.gnt == {N{1'b0}}) check("idle_s_cyc", 32'(bus.s_cyc), 32'd0);
      for (int i = 0; i < N; i++) begin
        if (!bus.gnt[i]) begin
          check("nongnt_ack", 32'(bus.m_ack[i]), 32'd0);
          check("nongnt_stall", 32'(bus.m_stall[i]), 32'd1);
        end
      end
      if (bus.gnt != prev_gnt && bus.gnt != {N{1'b0}}) begin
        for (int i = 0; i < N; i++) begin
          if (bus.gnt[i]) begin
            got_order.push_back(i);
            gnt_cycle[i] = cyc_cnt;
          end
        end
        if (seen_owner) gaps.push_back(zero_run);
        seen_owner = 1'b1;
      end
      zero_run = (bus.gnt == {N{1'b0}}) ? zero_run + 1 : 0;
      prev_gnt = bus.gnt;
      for (int i = 0; i < N; i++) begin
        if (bus.m_ack[i]) begin
          if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_ack: got ack on master %0d expected none", i);
          end else begin
            e = sbq.pop_front();
            check("ack_master", 32'(i), 32'(e.mst));
            if (!e.we) check("read_data", 32'(bus.m_dat_r), 32'(e.dat));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    clear_masters();
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_s_cyc", 32'(bus.s_cyc), 32'd0);
    check("rst_s_stb", 32'(bus.s_stb), 32'd0);
    check("rst_s_we", 32'(bus.s_we), 32'd0);
    check("rst_s_adr", 32'(bus.s_adr), 32'd0);
    check("rst_s_dat_w", 32'(bus.s_dat_w), 32'd0);
    check("rst_m_ack", 32'(bus.m_ack), 32'd0);
    check("rst_m_stall", 32'(bus.m_stall), 32'h7);
    rst = 1'b0;

    // Single master: write then read back 8'h35
    cmds.push_back(mk(0, 1'b1, 8'h35, 16'h0009));
    cmds.push_back(mk(0, 1'b0, 8'h35, 16'h0009));
    tick();
    @(posedge clk);
    #1;
    check("single_gnt_lat", 32'(bus.gnt), 32'h1);
    check("single_s_cyc_lat", 32'(bus.s_cyc), 32'd1);
    run_idle("single");

    // Contention from reset: grants 0,1,2 with one GAP each
    do_reset();
    cmds.push_back(mk(0, 1'b1, 8'h10, 16'h1111));
    cmds.push_back(mk(1, 1'b1, 8'h11, 16'h2222));
    cmds.push_back(mk(2, 1'b1, 8'h12, 16'h3333));
    run_idle("contention");
    check("cont_order", pack(got_order), 32'h123);
    check("cont_gaps", pack(gaps), 32'h22);

    // Fairness: m0 releases after every transfer and re-requests; m2 must get in second
    do_reset();
    drop_on_ack[0] = 1'b1;
    cmds.push_back(mk(0, 1'b1, 8'h40, 16'h4040));
    cmds.push_back(mk(0, 1'b1, 8'h41, 16'h4141));
    cmds.push_back(mk(0, 1'b1, 8'h42, 16'h4242));
    cmds.push_back(mk(2, 1'b1, 8'h50, 16'h5050));
    run_idle("fairness");
    check("fair_order", pack(got_order), 32'h1311);
    check("fair_gaps", pack(gaps), 32'h222);

    // Hold: m1 keeps the bus for five reads while m0 waits
    do_reset();
    for (int a = 0; a < 5; a++) cmds.push_back(mk(1, 1'b0, 8'(a), 16'hA500 | 16'(a)));
    tick();
    cmds.push_back(mk(0, 1'b1, 8'h20, 16'h2020));
    run_idle("hold");
    check("hold_order", pack(got_order), 32'h21);
    check("hold_handover", 32'(gnt_cycle[0] - last_drop[1]), 32'd2);

    // Late ack: m0 drops cyc in its ack cycle, memory repeats the ack into the GAP
    do_reset();
    cmds.push_back(mk(0, 1'b1, 8'h30, 16'h3030));
    tick();
    cmds.push_back(mk(1, 1'b1, 8'h31, 16'h3131));
    run_idle("late_ack");
    check("late_order", pack(got_order), 32'h12);
    check("late_handover", 32'(gnt_cycle[1] - last_drop[0]), 32'd2);

    // Reset in the middle of an m2 write
    do_reset();
    cmds.push_back(mk(2, 1'b1, 8'h60, 16'h6060));
    n = 0;
    while (!bus.m_stb[2] && n < 50) begin
      tick();
      n++;
    end
    check("midrst_stb", 32'(bus.m_stb[2]), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_gnt", 32'(bus.gnt), 32'd0);
    check("midrst_s_cyc", 32'(bus.s_cyc), 32'd0);
    check("midrst_stall", 32'(bus.m_stall), 32'h7);
    do_reset();
    cmds.push_back(mk(2, 1'b1, 8'h61, 16'h6161));
    cmds.push_back(mk(0, 1'b1, 8'h62, 16'h6262));
    run_idle("after_reset");
    check("after_rst_order", pack(got_order), 32'h13);
    check("sb_empty", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
